cache_req_arbiter: RTL and testbench

CACHE_REQ_ARBITER -- requirements
Module: cache_req_arbiter

---
 rtl/cache_req_arbiter_if.sv | 44 ++++
 rtl/cache_req_arbiter.sv | 135 +++++++++++++
 tb/tb_cache_req_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_req_arbiter_if.sv
// Request/response bundle between two cache ports, the arbiter and
// the cache controller.
interface cache_req_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  p0_valid;
    logic                  p1_valid;
    logic [1:0]            p0_op;
    logic [1:0]            p1_op;
    logic [ADDR_WIDTH-1:0] p0_addr;
    logic [ADDR_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p0_ready;
    logic                  p1_ready;
    logic                  p0_resp;
    logic                  p1_resp;
    logic                  resp_err;
    logic [1:0]            cpu_request;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cache_ready;
    logic                  cache_complete;
    logic                  timeout_sticky;

    modport master (
        output p0_valid, p1_valid, p0_op, p1_op,
        output p0_addr, p1_addr, p0_wdata, p1_wdata,
        output cache_ready, cache_complete,
        input  p0_ready, p1_ready, p0_resp, p1_resp,
        input  resp_err, cpu_request, cpu_addr,
        input  cpu_wdata, timeout_sticky
    );

    modport slave (
        input  p0_valid, p1_valid, p0_op, p1_op,
        input  p0_addr, p1_addr, p0_wdata, p1_wdata,
        input  cache_ready, cache_complete,
        output p0_ready, p1_ready, p0_resp, p1_resp,
        output resp_err, cpu_request, cpu_addr,
        output cpu_wdata, timeout_sticky
    );
endinterface

// File: rtl/cache_req_arbiter.sv
// Two-port round-robin arbiter in front of a cache controller,
// with a per-request completion timeout.
module cache_req_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input logic                clk,
    input logic                reset,
    cache_req_arbiter_if.slave bus
);
    localparam int CW =
        (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ERR
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_last;
    logic                  r_owner;
    logic                  r_sticky;
    logic [1:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [CW-1:0]         r_cnt;

    logic       w_live;
    logic       w_win;
    logic [1:0] w_op;
    logic       w_grant;
    logic       w_resp;
    logic       w_err;
    logic       w_tmo;

    assign w_live = ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_resp  = 1'b0;
        w_err   = 1'b0;
        w_tmo   = 1'b0;
        // on a tie the port that did not own the last request wins
        w_win = (bus.p0_valid && bus.p1_valid) ?
                ~r_last : ~bus.p0_valid;
        w_op  = w_win ? bus.p1_op : bus.p0_op;
        unique case (r_state)
            S_IDLE: begin
                if (bus.cache_ready &&
                    (bus.p0_valid || bus.p1_valid)) begin
                    w_grant = 1'b1;
                    unique case (w_op)
                        2'b00, 2'b01: w_next = S_ISSUE;
                        2'b10:        w_next = S_ERR;
                        default:      w_next = S_IDLE;
                    endcase
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (bus.cache_complete) begin
                    w_resp = 1'b1;
                    w_next = S_IDLE;
                end else if (r_cnt == TMAX) begin
                    w_resp = 1'b1;
                    w_err  = 1'b1;
                    w_tmo  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_ERR: begin
                w_resp = 1'b1;
                w_err  = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last   <= 1'b1;
            r_owner  <= 1'b0;
            r_sticky <= 1'b0;
            r_op     <= 2'b00;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_grant) begin
                r_op    <= w_op;
                r_owner <= w_win;
                r_addr  <= w_win ? bus.p1_addr : bus.p0_addr;
                r_wdata <= w_win ? bus.p1_wdata : bus.p0_wdata;
            end
            if (r_state == S_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT && !w_resp) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_resp) begin
                r_last <= r_owner;
            end
            if (w_tmo) begin
                r_sticky <= 1'b1;
            end
        end
    end

    assign bus.p0_ready = w_live & w_grant & ~w_win;
    assign bus.p1_ready = w_live & w_grant & w_win;
    assign bus.p0_resp  = w_live & w_resp & ~r_owner;
    assign bus.p1_resp  = w_live & w_resp & r_owner;
    assign bus.resp_err = w_live & w_resp & w_err;

    assign bus.cpu_request =
        (w_live && r_state == S_ISSUE) ? r_op : 2'b11;
    assign bus.cpu_addr  = w_live ? r_addr : '0;
    assign bus.cpu_wdata = w_live ? r_wdata : '0;
    assign bus.timeout_sticky = w_live & r_sticky;
endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: transaction-age reference model
// compared every cycle, plus hand-computed directed checks.
module tb_cache_req_arbiter;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    cache_req_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b ();

    cache_req_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(b.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t got %0h want %0h", n, $time, a, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in;
        b.p0_valid = 0; b.p1_valid = 0;
        b.p0_op = 2'b11; b.p1_op = 2'b11;
        b.p0_addr = 0; b.p1_addr = 0;
        b.p0_wdata = 0; b.p1_wdata = 0;
        b.cache_ready = 1; b.cache_complete = 0;
    endtask

    // Reference model: one outstanding transaction tracked by its age
    // in cycles since acceptance.
    logic        m_act, m_own, m_last, m_st;
    logic [1:0]  m_op;
    logic [31:0] m_addr, m_wd;
    int          m_age;
    logic        e_r0, e_r1, e_s0, e_s1, e_err, fin, tmo, gnt;
    logic [1:0]  e_req;
    int          win;

    always @(negedge clk) begin
        e_r0 = 0; e_r1 = 0; e_s0 = 0; e_s1 = 0; e_err = 0;
        e_req = 2'b11; fin = 0; tmo = 0; gnt = 0; win = 0;
        if (!reset && !m_act) begin
            if (b.cache_ready && (b.p0_valid || b.p1_valid)) begin
                gnt = 1;
                if (b.p0_valid && b.p1_valid) win = m_last ? 0 : 1;
                else win = b.p0_valid ? 0 : 1;
                e_r0 = (win == 0);
                e_r1 = (win == 1);
            end
        end else if (!reset && m_age == 1) begin
            if (m_op == 2'b10) begin
                fin = 1; e_err = 1;
            end else begin
                e_req = m_op;
            end
        end else if (!reset) begin
            if (b.cache_complete) begin
                fin = 1;
            end else if (m_age - 2 == TMO) begin
                fin = 1; e_err = 1; tmo = 1;
            end
        end
        e_s0 = fin && !m_own;
        e_s1 = fin && m_own;
        chk("m_p0_ready", b.p0_ready, e_r0);
        chk("m_p1_ready", b.p1_ready, e_r1);
        chk("m_p0_resp", b.p0_resp, e_s0);
        chk("m_p1_resp", b.p1_resp, e_s1);
        chk("m_resp_err", b.resp_err, e_err);
        chk("m_cpu_req", b.cpu_request, e_req);
        chk("m_cpu_addr", b.cpu_addr, reset ? 32'h0 : m_addr);
        chk("m_cpu_wdata", b.cpu_wdata, reset ? 32'h0 : m_wd);
        chk("m_sticky", b.timeout_sticky, !reset && m_st);
        if (reset) begin
            m_act = 0; m_last = 1; m_st = 0; m_own = 0;
            m_op = 0; m_addr = 0; m_wd = 0; m_age = 0;
        end else if (gnt) begin
            m_own  = (win == 1);
            m_op   = m_own ? b.p1_op : b.p0_op;
            m_addr = m_own ? b.p1_addr : b.p0_addr;
            m_wd   = m_own ? b.p1_wdata : b.p0_wdata;
            m_act  = (m_op != 2'b11);
            m_age  = 1;
        end else if (m_act) begin
            if (fin) begin
                m_act = 0;
                m_last = m_own;
                if (tmo) m_st = 1;
            end else begin
                m_age++;
            end
        end
    end

    int g[$];

    initial begin
        idle_in();
        reset = 1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_req", b.cpu_request, 2'b11);
            chk("rst_rdy", {b.p0_ready, b.p1_ready}, 0);
            chk("rst_addr", b.cpu_addr, 0);
            chk("rst_sticky", b.timeout_sticky, 0);
            tick();
        end
        reset = 0;

        // p0 read 0x100, complete two cycles after issue
        b.p0_valid = 1; b.p0_op = 2'b00; b.p0_addr = 32'h100;
        @(negedge clk);
        chk("rd_p0_ready", {b.p0_ready, b.p1_ready}, 2'b10);
        tick(); idle_in();
        @(negedge clk);
        chk("rd_issue", b.cpu_request, 2'b00);
        chk("rd_addr", b.cpu_addr, 32'h100);
        tick();
        @(negedge clk);
        chk("rd_wait_req", b.cpu_request, 2'b11);
        chk("rd_wait_resp", b.p0_resp, 0);
        tick(); b.cache_complete = 1;
        @(negedge clk);
        chk("rd_resp", {b.p0_resp, b.resp_err}, 2'b10);
        tick(); b.cache_complete = 0;
        @(negedge clk);
        chk("rd_after", b.p0_resp, 0);

        // op 11 is accepted silently and IDLE resumes at once
        tick(); b.p0_valid = 1; b.p0_op = 2'b11;
        @(negedge clk);
        chk("nop_ready", b.p0_ready, 1);
        tick(); b.p0_valid = 0;
        b.p1_valid = 1; b.p1_op = 2'b00; b.p1_addr = 32'h40;
        @(negedge clk);
        chk("nop_noresp", b.p0_resp, 0);
        chk("nop_p1_ready", b.p1_ready, 1);
        tick(); idle_in();
        tick(); b.cache_complete = 1;
        @(negedge clk);
        chk("nop_p1_resp", b.p1_resp, 1);
        tick(); b.cache_complete = 0;

        // reserved op on p1
        b.p1_valid = 1; b.p1_op = 2'b10;
        @(negedge clk);
        chk("rsv_ready", b.p1_ready, 1);
        tick(); idle_in();
        @(negedge clk);
        chk("rsv_resp", {b.p1_resp, b.resp_err}, 2'b11);
        chk("rsv_req", b.cpu_request, 2'b11);

        // complete on the same cycle the counter hits TIMEOUT
        tick(); b.p0_valid = 1; b.p0_op = 2'b00;
        @(negedge clk);
        tick(); idle_in();
        for (int i = 0; i < TMO; i++) begin
            tick();
            @(negedge clk);
            chk("race_noresp", b.p0_resp, 0);
        end
        tick(); b.cache_complete = 1;
        @(negedge clk);
        chk("race_resp", {b.p0_resp, b.resp_err}, 2'b10);
        tick(); b.cache_complete = 0;
        @(negedge clk);
        chk("race_sticky", b.timeout_sticky, 0);

        // write that never completes
        tick(); b.p0_valid = 1; b.p0_op = 2'b01;
        b.p0_addr = 32'h200; b.p0_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("to_ready", b.p0_ready, 1);
        tick(); idle_in();
        @(negedge clk);
        chk("to_issue", b.cpu_request, 2'b01);
        chk("to_wdata", b.cpu_wdata, 32'hDEAD_BEEF);
        for (int i = 0; i < TMO; i++) begin
            tick();
            @(negedge clk);
            chk("to_noresp", b.p0_resp, 0);
        end
        tick();
        @(negedge clk);
        chk("to_resp", {b.p0_resp, b.resp_err}, 2'b11);
        repeat (4) begin
            tick();
            @(negedge clk);
            chk("to_sticky", b.timeout_sticky, 1);
        end

        // grant held off while the controller is busy
        tick(); b.cache_ready = 0;
        b.p0_valid = 1; b.p0_op = 2'b00;
        repeat (5) begin
            @(negedge clk);
            chk("busy_noready", b.p0_ready, 0);
            tick();
        end
        b.cache_ready = 1;
        @(negedge clk);
        chk("busy_grant", b.p0_ready, 1);
        tick(); idle_in(); b.cache_complete = 1;
        @(negedge clk);
        chk("cmpl_ignored", b.p0_resp, 0);
        tick();
        @(negedge clk);
        chk("busy_resp", {b.p0_resp, b.resp_err}, 2'b10);
        tick(); idle_in();

        // reset while waiting abandons the request
        b.p1_valid = 1; b.p1_op = 2'b00;
        @(negedge clk);
        chk("rw_ready", b.p1_ready, 1);
        tick(); idle_in();
        tick();
        tick(); reset = 1;
        @(negedge clk);
        chk("rw_in_rst", {b.p0_resp, b.p1_resp, b.cpu_request}, 4'b0011);
        tick(); reset = 0;
        b.p0_valid = 1; b.p0_op = 2'b00; b.p0_addr = 32'h300;
        @(negedge clk);
        chk("rw_idle", {b.p1_resp, b.cpu_request}, 3'b011);
        chk("rw_grant", b.p0_ready, 1);
        chk("rw_sticky", b.timeout_sticky, 0);
        tick(); idle_in();
        @(negedge clk);
        chk("rw_issue", b.cpu_request, 2'b00);
        tick(); b.cache_complete = 1;
        @(negedge clk);
        chk("rw_resp", {b.p0_resp, b.resp_err}, 2'b10);
        tick(); idle_in();

        // continuous contention after reset alternates grants
        reset = 1;
        tick(); reset = 0;
        b.p0_valid = 1; b.p1_valid = 1;
        b.p0_op = 2'b00; b.p1_op = 2'b00;
        b.p0_addr = 32'hA0; b.p1_addr = 32'hB0;
        b.cache_complete = 1;
        repeat (12) begin
            @(negedge clk);
            if (b.p0_ready) g.push_back(0);
            if (b.p1_ready) g.push_back(1);
            tick();
        end
        idle_in();
        chk("rr_count", g.size(), 4);
        for (int i = 0; i < g.size(); i++)
            chk("rr_order", g[i], i % 2);

        // mixed traffic, checked by the model only
        repeat (400) begin
            b.p0_valid = $urandom_range(0, 1);
            b.p1_valid = $urandom_range(0, 1);
            b.p0_op = 2'($urandom_range(0, 3));
            b.p1_op = 2'($urandom_range(0, 3));
            b.p0_addr = $urandom; b.p1_addr = $urandom;
            b.p0_wdata = $urandom; b.p1_wdata = $urandom;
            b.cache_ready = ($urandom_range(0, 3) != 0);
            b.cache_complete = ($urandom_range(0, 4) == 0);
            reset = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            tick();
        end
        reset = 0;
        idle_in();
        tick();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
